c15xx_head_ctrl: RTL

Multi-drive head positioner and dirty-track flush controller for the 1541-family drive cores, clocked on clk_c1541. It decodes the stepper phases of NUM_DRIVES drive logics into half-track positions, tracks buffer modification per drive, and issues track save requests to the shared SD track loader. A shared save channel is arbitrated round-robin across drives, and a per-drive settle/ready signal gates GCR buffer access.

---
 rtl/c15xx_pkg.sv | 33 +++
 rtl/c15xx_head_pos.sv | 138 +++++++++++++
 rtl/c15xx_head_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/c15xx_pkg.sv
// Shared defaults, step direction type and arbiter states for the 1541-family head controller.
package c15xx_pkg;

   localparam int unsigned HT_W_DEF         = 7;
   localparam int unsigned START_HTRACK_DEF = 36;
   localparam int unsigned MAX_HTRACK_DEF   = 80;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_IN,
      STEP_OUT
   } step_e;

   typedef enum logic {
      ARB_IDLE,
      ARB_WAIT
   } arb_state_e;

   // Phase +1 (mod 4) is inward, -1 is outward; a difference of 0 or 2 means no step.
   function automatic step_e step_decode(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] inc;
      logic [1:0] dec;
      inc = prev + 2'd1;
      dec = prev - 2'd1;
      if (cur == inc) begin
         return STEP_IN;
      end else if (cur == dec) begin
         return STEP_OUT;
      end
      return STEP_NONE;
   endfunction

endpackage

// File: rtl/c15xx_head_pos.sv
// Per-drive head position: stepper decode with clamping, dirty/pending track tracking,
// settle counter and sticky overrun flag.
module c15xx_head_pos
   import c15xx_pkg::*;
#(
   parameter int unsigned MAX_HTRACK    = MAX_HTRACK_DEF,
   parameter int unsigned START_HTRACK  = START_HTRACK_DEF,
   parameter int unsigned SETTLE_CYCLES = 96000,
   parameter int unsigned HT_W          = HT_W_DEF
) (
   input  logic            clk_c1541,
   input  logic            reset,
   input  logic [1:0]      stp,
   input  logic            mtr,
   input  logic            act,
   input  logic            buff_we,
   input  logic            disk_change,
   input  logic            granted,
   input  logic            save_done,
   output logic [HT_W-1:0] half_track,
   output logic [HT_W-2:0] track,
   output logic            tr00_sense_n,
   output logic            track_ready,
   output logic            pending,
   output logic [HT_W-2:0] pend_track,
   output logic            overrun
);

   localparam int unsigned CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [HT_W-1:0]  HT_MAX   = HT_W'(MAX_HTRACK);
   localparam logic [HT_W-1:0]  HT_START = HT_W'(START_HTRACK);
   localparam logic [HT_W-1:0]  HT_ONE   = HT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]      stp_q;
   logic            act_q;
   logic [HT_W-1:0] ht_q, ht_d;
   logic [HT_W-2:0] trk_q;
   logic            tr00_n_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            dirty_q, dirty_d;
   logic            pend_q, pend_d;
   logic [HT_W-2:0] pend_trk_q, pend_trk_d;
   logic            ovr_q, ovr_d;

   step_e dir;
   logic  move;
   logic  act_fall;
   logic  ready;
   logic  capture;

   // Step decode, clamp, and dirty/pending/settle/overrun next state.
   always_comb begin
      dir      = mtr ? step_decode(stp_q, stp) : STEP_NONE;
      move     = 1'b0;
      ht_d     = ht_q;
      if (dir == STEP_IN && ht_q < HT_MAX) begin
         move = 1'b1;
         ht_d = ht_q + HT_ONE;
      end else if (dir == STEP_OUT && ht_q > HT_ONE) begin
         move = 1'b1;
         ht_d = ht_q - HT_ONE;
      end

      act_fall = act_q & ~act;
      ready    = (cnt_q == '0) & ~pend_q;

      // Same-cycle buff_we counts as dirty for the old track; the slot is only
      // refilled once the previous entry is free (or being acknowledged now).
      capture  = (move | act_fall) & (dirty_q | buff_we) & ~disk_change & (~pend_q | save_done);

      dirty_d = dirty_q;
      if (disk_change) begin
         dirty_d = 1'b0;
      end else if (capture) begin
         dirty_d = 1'b0;
      end else if (buff_we) begin
         dirty_d = 1'b1;
      end

      pend_d = pend_q;
      if (disk_change && !granted) begin
         pend_d = 1'b0;
      end else if (capture) begin
         pend_d = 1'b1;
      end else if (save_done) begin
         pend_d = 1'b0;
      end

      pend_trk_d = capture ? ht_q[HT_W-1:1] : pend_trk_q;

      cnt_d = cnt_q;
      if (move) begin
         cnt_d = CNT_LOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
      end

      ovr_d = ovr_q | (buff_we & ~ready);
   end

   // State registers; track and tr00 lag half_track by one cycle.
   always_ff @(posedge clk_c1541) begin
      if (reset) begin
         stp_q      <= 2'd0;
         act_q      <= 1'b0;
         ht_q       <= HT_START;
         trk_q      <= HT_START[HT_W-1:1];
         tr00_n_q   <= 1'b1;
         cnt_q      <= '0;
         dirty_q    <= 1'b0;
         pend_q     <= 1'b0;
         pend_trk_q <= '0;
         ovr_q      <= 1'b0;
      end else begin
         stp_q      <= stp;
         act_q      <= act;
         ht_q       <= ht_d;
         trk_q      <= ht_q[HT_W-1:1];
         tr00_n_q   <= |ht_q[HT_W-1:1];
         cnt_q      <= cnt_d;
         dirty_q    <= dirty_d;
         pend_q     <= pend_d;
         pend_trk_q <= pend_trk_d;
         ovr_q      <= ovr_d;
      end
   end

   assign half_track   = ht_q;
   assign track        = trk_q;
   assign tr00_sense_n = tr00_n_q;
   assign track_ready  = ready;
   assign pending      = pend_q;
   assign pend_track   = pend_trk_q;
   assign overrun      = ovr_q;

endmodule

// File: rtl/c15xx_head_ctrl.sv
// Multi-drive head positioner with a round-robin arbitrated track save channel.
module c15xx_head_ctrl
   import c15xx_pkg::*;
#(
   parameter int unsigned NUM_DRIVES    = 1,
   parameter int unsigned MAX_HTRACK    = MAX_HTRACK_DEF,
   parameter int unsigned START_HTRACK  = START_HTRACK_DEF,
   parameter int unsigned SETTLE_CYCLES = 96000,
   parameter int unsigned HT_W          = HT_W_DEF
) (
   input  logic                         clk_c1541,
   input  logic                         reset,
   input  logic [2*NUM_DRIVES-1:0]      stp,
   input  logic [NUM_DRIVES-1:0]        mtr,
   input  logic [NUM_DRIVES-1:0]        act,
   input  logic [NUM_DRIVES-1:0]        buff_we,
   input  logic [NUM_DRIVES-1:0]        disk_change,
   output logic [HT_W*NUM_DRIVES-1:0]   half_track,
   output logic [(HT_W-1)*NUM_DRIVES-1:0] track,
   output logic [NUM_DRIVES-1:0]        tr00_sense_n,
   output logic [NUM_DRIVES-1:0]        track_ready,
   output logic                         save_req,
   output logic [1:0]                   save_drive,
   output logic [HT_W-2:0]              save_track,
   input  logic                         save_ack,
   output logic [NUM_DRIVES-1:0]        overrun
);

   logic [NUM_DRIVES-1:0] pending;
   logic [NUM_DRIVES-1:0] granted;
   logic [NUM_DRIVES-1:0] save_done;
   logic [HT_W-2:0]       pend_track [NUM_DRIVES];

   arb_state_e      state_q, state_d;
   logic [1:0]      last_q, last_d;
   logic            req_q, req_d;
   logic [1:0]      drv_q, drv_d;
   logic [HT_W-2:0] trk_q, trk_d;

   logic [NUM_DRIVES-1:0] eligible;
   logic                  found;
   logic [1:0]            pick;
   logic [HT_W-2:0]       pick_trk;

   for (genvar d = 0; d < NUM_DRIVES; d++) begin : g_drive
      assign granted[d]   = (state_q == ARB_WAIT) && (drv_q == 2'(d));
      assign save_done[d] = granted[d] & save_ack;

      c15xx_head_pos #(
         .MAX_HTRACK    (MAX_HTRACK),
         .START_HTRACK  (START_HTRACK),
         .SETTLE_CYCLES (SETTLE_CYCLES),
         .HT_W          (HT_W)
      ) u_head_pos (
         .clk_c1541    (clk_c1541),
         .reset        (reset),
         .stp          (stp[2*d +: 2]),
         .mtr          (mtr[d]),
         .act          (act[d]),
         .buff_we      (buff_we[d]),
         .disk_change  (disk_change[d]),
         .granted      (granted[d]),
         .save_done    (save_done[d]),
         .half_track   (half_track[HT_W*d +: HT_W]),
         .track        (track[(HT_W-1)*d +: (HT_W-1)]),
         .tr00_sense_n (tr00_sense_n[d]),
         .track_ready  (track_ready[d]),
         .pending      (pending[d]),
         .pend_track   (pend_track[d]),
         .overrun      (overrun[d])
      );
   end

   // Round-robin pick: lowest pending index above the last grant, else wrap to the lowest.
   // A drive whose image is being swapped this cycle is not eligible.
   always_comb begin
      eligible = pending & ~disk_change;
      found    = 1'b0;
      pick     = 2'd0;
      pick_trk = '0;
      for (int unsigned j = 0; j < NUM_DRIVES; j++) begin
         if (!found && eligible[j] && (j > 32'(last_q))) begin
            found    = 1'b1;
            pick     = 2'(j);
            pick_trk = pend_track[j];
         end
      end
      for (int unsigned j = 0; j < NUM_DRIVES; j++) begin
         if (!found && eligible[j] && (j <= 32'(last_q))) begin
            found    = 1'b1;
            pick     = 2'(j);
            pick_trk = pend_track[j];
         end
      end
   end

   // Arbiter next state: grant in idle, hold request fields until save_ack.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      req_d   = req_q;
      drv_d   = drv_q;
      trk_d   = trk_q;
      case (state_q)
         ARB_IDLE: begin
            if (found) begin
               state_d = ARB_WAIT;
               req_d   = 1'b1;
               drv_d   = pick;
               trk_d   = pick_trk;
               last_d  = pick;
            end
         end
         ARB_WAIT: begin
            if (save_ack) begin
               state_d = ARB_IDLE;
               req_d   = 1'b0;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // Arbiter state register; reset abandons any outstanding request.
   always_ff @(posedge clk_c1541) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         last_q  <= 2'(NUM_DRIVES - 1);
         req_q   <= 1'b0;
         drv_q   <= 2'd0;
         trk_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         req_q   <= req_d;
         drv_q   <= drv_d;
         trk_q   <= trk_d;
      end
   end

   assign save_req   = req_q;
   assign save_drive = drv_q;
   assign save_track = trk_q;

endmodule
